// File: rtl/iomem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iomem_pkg
// Brief    : Shared types and constants for the iomem bridge and its timer.
// Revision : 1.0 - initial release
// ============================================================================
package iomem_pkg;

  // Bridge control states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAM_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  // Byte offsets of the timer registers inside the 16-byte window
  localparam logic [3:0] c_off_mtime_lo    = 4'h0;
  localparam logic [3:0] c_off_mtime_hi    = 4'h4;
  localparam logic [3:0] c_off_mtimecmp_lo = 4'h8;
  localparam logic [3:0] c_off_mtimecmp_hi = 4'hC;

  // Data returned for accesses that hit no target
  localparam logic [31:0] c_unmapped_rdata = 32'h0000_0000;

  // Replace the bytes of old_w selected by strb with the bytes of new_w
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iomem_mtimer.sv
`default_nettype none
// ============================================================================
// Module   : iomem_mtimer
// Brief    : Machine timer: prescaled 64-bit mtime, mtimecmp, byte-merge
//            register writes and a registered compare interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module iomem_mtimer
  import iomem_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en,
  input  logic [3:0]  wr_off,
  input  logic [3:0]  wr_strb,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        timer_irq_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] c_presc_reload = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_irq;
  logic          w_tick;
  logic [63:0]   w_mtime_nxt;
  logic [63:0]   w_cmp_nxt;

  assign w_tick      = (r_presc == '0);
  assign timer_irq_o = r_irq;

  // Next timer state: tick increment first, then software bytes override it
  always_comb begin
    w_mtime_nxt = w_tick ? (r_mtime + 64'd1) : r_mtime;
    w_cmp_nxt   = r_mtimecmp;
    if (wr_en) begin
      case (wr_off)
        c_off_mtime_lo:    w_mtime_nxt[31:0]  = merge_bytes(w_mtime_nxt[31:0],  wr_data, wr_strb);
        c_off_mtime_hi:    w_mtime_nxt[63:32] = merge_bytes(w_mtime_nxt[63:32], wr_data, wr_strb);
        c_off_mtimecmp_lo: w_cmp_nxt[31:0]    = merge_bytes(r_mtimecmp[31:0],   wr_data, wr_strb);
        c_off_mtimecmp_hi: w_cmp_nxt[63:32]   = merge_bytes(r_mtimecmp[63:32],  wr_data, wr_strb);
        default: ;
      endcase
    end
  end

  // Register read mux on the current (pre-update) values
  always_comb begin
    rd_data = c_unmapped_rdata;
    case (wr_off)
      c_off_mtime_lo:    rd_data = r_mtime[31:0];
      c_off_mtime_hi:    rd_data = r_mtime[63:32];
      c_off_mtimecmp_lo: rd_data = r_mtimecmp[31:0];
      c_off_mtimecmp_hi: rd_data = r_mtimecmp[63:32];
      default:           rd_data = c_unmapped_rdata;
    endcase
  end

  // Prescaler, counters and the compare flag, one cycle behind the registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_presc    <= '0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= '1;
      r_irq      <= 1'b0;
    end else begin
      r_presc    <= w_tick ? c_presc_reload : (r_presc - 1'b1);
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_cmp_nxt;
      r_irq      <= (r_mtime >= r_mtimecmp);
    end
  end

endmodule
`default_nettype wire

// File: rtl/iomem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : iomem_bridge
// Brief    : iomem bus responder decoding RAM window, machine timer and
//            unmapped space; every request ends in a one-cycle ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
module iomem_bridge
  import iomem_pkg::*;
#(
  parameter logic [31:0] RAM_BASE    = 32'h4000_0000,
  parameter logic [31:0] RAM_MASK    = 32'h000F_FFFF,
  parameter int          RAM_LATENCY = 16,
  parameter logic [31:0] TIMER_BASE  = 32'h3000_0000,
  parameter int          PRESCALE    = 1,
  parameter int          MEM_AW      = 17
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              iomem_valid,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic              iomem_ready,
  output logic [31:0]       iomem_rdata,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  output logic              mem_rd_en_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              timer_irq_o,
  output logic              bus_err_o
);

  // The issue cycle and the capture cycle are both inside the latency budget
  localparam logic [7:0] c_lat_load = 8'(RAM_LATENCY - 2);

  state_t      r_state;
  logic [7:0]  r_lat_cnt;
  logic        r_ready;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        w_ram_hit;
  logic        w_tmr_hit;
  logic        w_tmr_we;
  logic [3:0]  w_tmr_off;
  logic [31:0] w_tmr_rdata;

  assign w_ram_hit = ((iomem_addr & ~RAM_MASK) == RAM_BASE);
  assign w_tmr_hit = ((iomem_addr & ~32'h0000_000F) == TIMER_BASE);
  assign w_tmr_off = {iomem_addr[3:2], 2'b00};
  // Timer writes land at the end of the acceptance cycle
  assign w_tmr_we  = (r_state == ST_IDLE) && iomem_valid && !w_ram_hit &&
                     w_tmr_hit && (iomem_wstrb != 4'b0000);

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign bus_err_o   = r_err;

  iomem_mtimer #(
    .PRESCALE (PRESCALE)
  ) u_mtimer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_en       (w_tmr_we),
    .wr_off      (w_tmr_off),
    .wr_strb     (iomem_wstrb),
    .wr_data     (iomem_wdata),
    .rd_data     (w_tmr_rdata),
    .timer_irq_o (timer_irq_o)
  );

  // Request FSM with registered RAM issue strobes, ready, error and read data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_lat_cnt   <= 8'd0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'd0;
      mem_wstrb_o <= 4'b0000;
      mem_rd_en_o <= 1'b0;
    end else begin
      mem_wstrb_o <= 4'b0000;
      mem_rd_en_o <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iomem_valid) begin
            if (w_ram_hit) begin
              mem_addr_o  <= iomem_addr[MEM_AW+1:2];
              mem_wdata_o <= iomem_wdata;
              mem_wstrb_o <= iomem_wstrb;
              mem_rd_en_o <= (iomem_wstrb == 4'b0000);
              r_lat_cnt   <= c_lat_load;
              r_state     <= ST_RAM_WAIT;
            end else if (w_tmr_hit) begin
              r_rdata <= w_tmr_rdata;
              r_ready <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_rdata <= c_unmapped_rdata;
              r_err   <= 1'b1;
              r_ready <= 1'b1;
              r_state <= ST_RESP;
            end
          end
        end
        ST_RAM_WAIT: begin
          if (r_lat_cnt == 8'd0) begin
            r_rdata <= mem_rdata_i;
            r_ready <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 8'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iomem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_iomem_bridge
// Brief    : Randomised scoreboard bench for iomem_bridge with a RAM model
//            and a cycle-arithmetic model of the machine timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iomem_bridge;

  localparam logic [31:0] RAM_BASE   = 32'h4000_0000;
  localparam logic [31:0] RAM_MASK   = 32'h000F_FFFF;
  localparam int          L          = 16;
  localparam logic [31:0] TIMER_BASE = 32'h3000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'b0;
  logic [31:0] iomem_addr = 32'd0;
  logic [31:0] iomem_wdata = 32'd0;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic [16:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_rd_en_o;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        timer_irq_o;
  logic        bus_err_o;

  always #5 clk_i = ~clk_i;

  iomem_bridge #(
    .RAM_BASE(RAM_BASE), .RAM_MASK(RAM_MASK), .RAM_LATENCY(L),
    .TIMER_BASE(TIMER_BASE), .PRESCALE(1), .MEM_AW(17)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .iomem_valid(iomem_valid),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_ready(iomem_ready), .iomem_rdata(iomem_rdata), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_rdata_i(mem_rdata_i), .timer_irq_o(timer_irq_o), .bus_err_o(bus_err_o)
  );

  typedef struct { int due; logic [31:0] rdata; logic chk_rd; logic err; } resp_t;
  typedef struct { int due; logic [16:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } iss_t;

  resp_t rq[$];
  iss_t  iq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic  prev_ready = 1'b0;

  // Memory contents: environment (driven by DUT strobes) and reference (driven by requests)
  logic [31:0] env_mem [logic [16:0]];
  logic [31:0] ref_mem [logic [16:0]];

  // Timer model: mtime = m_base + (cycle - m_base_cyc) with PRESCALE 1
  logic [63:0] m_base = 64'd0;
  int          m_base_cyc = 0;
  logic [63:0] m_cmp = '1;

  function automatic logic [31:0] init_word(input logic [16:0] a);
    return 32'h5A5A_0000 ^ {15'h0, a} ^ {a, 15'h0};
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] env_rd(input logic [16:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [16:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [63:0] m_mtime(input int c);
    return m_base + 64'(c - m_base_cyc);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter, zero while in reset
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // RAM environment: one-cycle read latency after the issue strobe
  always @(posedge clk_i) begin
    if (mem_rd_en_o) mem_rdata_i <= env_rd(mem_addr_o);
  end
  always @(posedge clk_i) begin
    if (mem_wstrb_o != 4'b0) env_mem[mem_addr_o] = bmerge(env_rd(mem_addr_o), mem_wdata_o, mem_wstrb_o);
  end

  // Monitor: compares responses and issue strobes against the queues
  always @(negedge clk_i) begin
    resp_t r;
    iss_t  s;
    if (rq.size() > 0 && rq[0].due < cyc) begin
      chk("ready_missing", cyc, rq[0].due);
      void'(rq.pop_front());
    end
    if (iomem_ready) begin
      if (rq.size() == 0) begin
        chk("ready_unexpected", iomem_ready, 0);
      end else begin
        r = rq.pop_front();
        chk("ready_cycle", cyc, r.due);
        if (r.chk_rd) chk("rdata", iomem_rdata, r.rdata);
        chk("bus_err", bus_err_o, r.err);
      end
    end else if (bus_err_o) begin
      chk("bus_err_without_ready", bus_err_o, 0);
    end
    if (iomem_ready && prev_ready) chk("ready_two_cycles", prev_ready, 0);
    prev_ready <= iomem_ready;
    if (iq.size() > 0 && iq[0].due < cyc) begin
      chk("issue_missing", cyc, iq[0].due);
      void'(iq.pop_front());
    end
    if (iq.size() > 0 && iq[0].due == cyc) begin
      s = iq.pop_front();
      chk("issue_rd_en", mem_rd_en_o, (s.wstrb == 4'b0));
      chk("issue_wstrb", mem_wstrb_o, s.wstrb);
      chk("issue_addr", mem_addr_o, s.addr);
      if (s.wstrb != 4'b0) chk("issue_wdata", mem_wdata_o, s.wdata);
    end else if (mem_rd_en_o || mem_wstrb_o != 4'b0) begin
      chk("strobe_unexpected", {mem_rd_en_o, mem_wstrb_o}, 0);
    end
  end

  // One bus transaction: predict the response at acceptance, then wait for ready
  task automatic do_req(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    resp_t       r;
    iss_t        s;
    int          t0;
    int          n;
    logic [16:0] wa;
    logic [63:0] cur;
    logic [63:0] nxt;
    @(negedge clk_i);
    t0 = cyc;
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = data;
    r.err = 1'b0; r.chk_rd = (strb == 4'b0); r.rdata = 32'd0; r.due = t0 + 1;
    if ((addr & ~RAM_MASK) == RAM_BASE) begin
      wa = addr[18:2];
      s.due = t0 + 1; s.addr = wa; s.wdata = data; s.wstrb = strb;
      iq.push_back(s);
      r.due = t0 + L;
      if (strb == 4'b0) r.rdata = ref_rd(wa);
      else              ref_mem[wa] = bmerge(ref_rd(wa), data, strb);
    end else if ((addr & ~32'hF) == TIMER_BASE) begin
      cur = m_mtime(t0);
      case (addr[3:2])
        2'd0: r.rdata = cur[31:0];
        2'd1: r.rdata = cur[63:32];
        2'd2: r.rdata = m_cmp[31:0];
        default: r.rdata = m_cmp[63:32];
      endcase
      if (strb != 4'b0) begin
        nxt = cur + 64'd1;
        case (addr[3:2])
          2'd0: begin nxt[31:0] = bmerge(nxt[31:0], data, strb); m_base = nxt; m_base_cyc = t0 + 1; end
          2'd1: begin nxt[63:32] = bmerge(nxt[63:32], data, strb); m_base = nxt; m_base_cyc = t0 + 1; end
          2'd2: m_cmp[31:0] = bmerge(m_cmp[31:0], data, strb);
          default: m_cmp[63:32] = bmerge(m_cmp[63:32], data, strb);
        endcase
      end
    end else begin
      r.err = 1'b1; r.chk_rd = 1'b1; r.rdata = 32'd0;
    end
    rq.push_back(r);
    n = 0;
    while (!iomem_ready && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (!iomem_ready) chk("req_complete", iomem_ready, 1);
    iomem_valid = 1'b0; iomem_wstrb = 4'b0;
  endtask

  task automatic apply_reset(input int hold);
    rst_ni = 1'b0;
    iomem_valid = 1'b0; iomem_wstrb = 4'b0;
    rq.delete(); iq.delete();
    m_base = 64'd0; m_base_cyc = 0; m_cmp = '1;
    #1;
    chk("rst_ready", iomem_ready, 0);
    chk("rst_rdata", iomem_rdata, 0);
    chk("rst_wstrb", mem_wstrb_o, 0);
    chk("rst_rd_en", mem_rd_en_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    chk("rst_irq", timer_irq_o, 0);
    repeat (hold) @(negedge clk_i);
    chk("rst_hold_ready", iomem_ready, 0);
    chk("rst_hold_strobes", {mem_rd_en_o, mem_wstrb_o}, 0);
    rst_ni = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int          x;
    int          t0;
    int          k;
    logic [31:0] a;
    logic [16:0] wa;
    iss_t        s;
    env_mem[17'd4] = 32'hCAFE_F00D;
    ref_mem[17'd4] = 32'hCAFE_F00D;
    #1;
    apply_reset(3);

    // Compare interrupt at mtime == 100
    do_req(TIMER_BASE + 32'hC, 4'hF, 32'd0);
    do_req(TIMER_BASE + 32'h8, 4'hF, 32'd100);
    x = m_base_cyc + int'(32'd100 - m_base[31:0]);
    while (cyc < x) @(negedge clk_i);
    chk("mtime_at_100", m_mtime(cyc), 100);
    chk("irq_before", timer_irq_o, (m_mtime(cyc - 1) >= m_cmp));
    @(negedge clk_i);
    chk("irq_rise", timer_irq_o, (m_mtime(cyc - 1) >= m_cmp));
    do_req(TIMER_BASE + 32'h8, 4'hF, 32'hFFFF_FFFF);
    do_req(TIMER_BASE + 32'hC, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk_i);
    chk("irq_drop", timer_irq_o, (m_mtime(cyc - 1) >= m_cmp));

    // Directed RAM read and partial write
    do_req(32'h4000_0010, 4'b0000, 32'd0);
    do_req(32'h4000_0004, 4'b0011, 32'h1234_5678);
    do_req(32'h4000_0004, 4'b0000, 32'd0);

    // Carry from mtime low into high
    do_req(TIMER_BASE + 32'h4, 4'b0, 32'd0);
    do_req(TIMER_BASE + 32'h0, 4'hF, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk_i);
    do_req(TIMER_BASE + 32'h4, 4'b0, 32'd0);

    // Unmapped access followed back-to-back by RAM
    do_req(32'h1000_0000, 4'b0, 32'd0);
    do_req(32'h4000_0010, 4'b0, 32'd0);
    do_req(32'h1000_0040, 4'hF, 32'hDEAD_BEEF);
    do_req(32'h4000_0008, 4'hF, 32'hA5A5_5A5A);

    // Randomised mix
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      if (k < 4) begin
        do_req(RAM_BASE | ($urandom & RAM_MASK), 4'b0, 32'd0);
      end else if (k < 7) begin
        do_req(RAM_BASE | ($urandom & RAM_MASK), 4'($urandom_range(1, 15)), $urandom);
      end else if (k < 9) begin
        a = TIMER_BASE | ($urandom_range(0, 3) * 4);
        if ($urandom_range(0, 3) == 0) do_req(a, 4'($urandom_range(1, 15)), $urandom);
        else                           do_req(a, 4'b0, 32'd0);
      end else begin
        do_req(32'h1000_0000 | ($urandom & 32'h0FFF_FFFF),
               ($urandom_range(0, 1) == 0) ? 4'b0 : 4'hF, $urandom);
      end
    end

    // Reset in the middle of a RAM read
    @(negedge clk_i);
    t0 = cyc;
    a = 32'h4000_0020;
    wa = a[18:2];
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = 4'b0; iomem_wdata = 32'd0;
    s.due = t0 + 1; s.addr = wa; s.wdata = 32'd0; s.wstrb = 4'b0;
    iq.push_back(s);
    repeat (5) @(negedge clk_i);
    apply_reset(4);
    repeat (4) @(negedge clk_i);
    do_req(TIMER_BASE + 32'h0, 4'b0, 32'd0);
    do_req(TIMER_BASE + 32'hC, 4'b0, 32'd0);
    do_req(32'h4000_0010, 4'b0, 32'd0);

    repeat (3) @(negedge clk_i);
    chk("resp_queue_drained", rq.size(), 0);
    chk("issue_queue_drained", iq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iomem_bridge.md
# iomem_bridge

Parametrised responder on the core's `iomem` bus, placed between `user_processor` and main memory. It decodes each request to one of three targets: the RAM window, a memory-mapped machine timer (`mtime`/`mtimecmp` with interrupt), or unmapped space. It completes every request with a single-cycle `iomem_ready` pulse. RAM latency comes from a loadable down-counter, not a fixed shift chain, and unmapped accesses complete with an error flag instead of hanging the bus.

## Interface
- `RAM_BASE`, 32'h4000_0000, RAM window base
- `RAM_MASK`, 32'h000F_FFFF, RAM window offset mask; hit when `(addr & ~RAM_MASK) == RAM_BASE`
- `RAM_LATENCY`, 16, cycles from request acceptance to `iomem_ready`; legal range 2..255
- `TIMER_BASE`, 32'h3000_0000, timer block base, 16-byte window
- `PRESCALE`, 1, clock cycles per `mtime` increment; minimum 1
- `MEM_AW`, 17, word-address width to memory
- `clk_i` in 1: system clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `iomem_valid` in 1: request valid, held until ready
- `iomem_wstrb` in 4: byte write strobes; 0 means read
- `iomem_addr` in 32: byte address
- `iomem_wdata` in 32: write data
- `iomem_ready` out 1: one-cycle completion pulse
- `iomem_rdata` out 32: read data, valid while `iomem_ready`
- `mem_addr_o` out MEM_AW: word address, `iomem_addr[MEM_AW+1:2]`
- `mem_wdata_o` out 32: write data to RAM
- `mem_wstrb_o` out 4: RAM byte strobes, one-cycle issue
- `mem_rd_en_o` out 1: RAM read enable, one-cycle issue
- `mem_rdata_i` in 32: RAM read data
- `timer_irq_o` out 1: registered, high while `mtime >= mtimecmp` (unsigned)
- `bus_err_o` out 1: one-cycle pulse coinciding with ready on an unmapped access

## Operation
- FSM states: IDLE, RAM_WAIT, RESP.
- IDLE, `iomem_valid` high, RAM hit:
  - latch addr, wdata and wstrb; go to RAM_WAIT.
  - next cycle (issue cycle): drive `mem_wstrb_o = wstrb` for a write, or `mem_rd_en_o = 1` for a read, for exactly one cycle.
  - counter loads `RAM_LATENCY-2`.
- RAM_WAIT: decrement the counter. At zero, capture `mem_rdata_i` into the rdata register and go to RESP.
- IDLE, timer hit:
  - reads select a register: +0 `mtime[31:0]`, +4 `mtime[63:32]`, +8 `mtimecmp[31:0]`, +C `mtimecmp[63:32]`.
  - writes merge per byte strobe.
  - go to RESP.
- IDLE, neither hit: rdata is 0, set error flag, go to RESP.
- RESP: `iomem_ready=1`, `bus_err_o` = error flag; return to IDLE. Valid high in the following cycle is a new request.
- `mtime` prescaler counts `PRESCALE-1`..0; `mtime` increments by 1 on reaching 0; 64-bit wrap to 0.
- Simultaneous software write and tick on `mtime`: the written bytes win, and the increment is dropped that cycle. Unwritten bytes take the incremented value.
- The timer runs regardless of bus state.

## Timing
- Reset values:
  - state IDLE; `iomem_ready` 0; `iomem_rdata` 0.
  - `mem_wstrb_o` 0; `mem_rd_en_o` 0; `mem_addr_o` 0; `mem_wdata_o` 0.
  - `bus_err_o` 0; `timer_irq_o` 0.
  - `mtime` 0; `mtimecmp` all ones; prescaler 0.
- Acceptance cycle T0 = IDLE with valid high.
- RAM access:
  - issue strobe at T0+1.
  - `mem_rdata_i` sampled at the end of T0+RAM_LATENCY-1.
  - `iomem_ready` at T0+RAM_LATENCY.
  - memory read latency must be ≤ RAM_LATENCY-2 cycles after issue.
- Timer or unmapped access: `iomem_ready` at T0+1. Register writes take effect at the end of T0.
- `timer_irq_o` updates one cycle after `mtime` or `mtimecmp` changes.
- Asynchronous reset mid-access: abandon the access and force all reset values immediately. No strobe may be emitted after reset deassertion unless a new valid arrives.
- `iomem_ready` is never high for two consecutive cycles.

## Structure
- Shared package `iomem_pkg`:
  - FSM state enum.
  - timer register offsets (0x0, 0x4, 0x8, 0xC).
  - unmapped read value (32'h0).
- One sub-module, `iomem_mtimer`: prescaler, `mtime`, `mtimecmp`, byte-merge writes, `timer_irq_o`.
- The top level holds the decoder, the FSM, the latency counter and the rdata register.

## Test plan
- Read at 0x4000_0010 with `RAM_LATENCY=16` and a model returning 32'hCAFE_F00D: one `mem_rd_en_o` pulse at T0+1, `mem_addr_o=4`, ready at T0+16, rdata 32'hCAFE_F00D.
- Write at 0x4000_0004, wstrb 4'b0011, data 32'h1234_5678: one-cycle `mem_wstrb_o=4'b0011` at T0+1, ready at T0+16, no `mem_rd_en_o`.
- Timer with PRESCALE=1:
  - write `mtimecmp` high/low = 0/100; `timer_irq_o` rises exactly one cycle after `mtime` reaches 100.
  - write `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF; `timer_irq_o` drops.
- Write `mtime` low = 32'hFFFF_FFFF, then read high twice ≥2 cycles apart: high word increments 0→1 (carry), ready at T0+1 each.
- Read at 0x1000_0000: ready at T0+1, rdata 0, `bus_err_o` pulse coincident with ready. Back-to-back RAM request completes normally.
- Assert `rst_ni` low at T0+5 of a RAM read: ready never rises, strobes 0, `mtime` 0. Release reset: next request completes at T0'+RAM_LATENCY.
